// File: rtl/padder_pkg.sv
// Shared types and elaboration helpers for the pipelined parallel-prefix adder.
package padder_pkg;

  localparam int PADDER_MAX_N = 64;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

  // Per-beat control carried alongside the data; cin is already resolved for subtraction.
  typedef struct packed {
    logic valid;
    logic chain;
    logic cin;
  } ctl_t;

  function automatic int padder_levels(input int n);
    return $clog2(n);
  endfunction

  // True when a pipeline register sits on the output of prefix level lvl.
  function automatic bit padder_is_cut(input int lvl, input int levels, input int regs);
    bit hit;
    hit = 1'b0;
    for (int r = 1; r <= regs; r++) begin
      if ((r * levels) / regs == lvl) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/padder_pg_cell.sv
// Group propagate/generate combine cell of the Sklansky prefix tree.
module padder_pg_cell (
  input  logic Phi,
  input  logic Plo,
  input  logic Ghi,
  input  logic Glo,
  output logic P,
  output logic G
);

  assign P = Phi & Plo;
  assign G = Ghi | (Phi & Glo);

endmodule

// File: rtl/padder_pipe.sv
// Pipelined Sklansky adder/subtractor with multi-word chaining and valid/ready flow.
// Optional signed-overflow output is enabled by defining PADDER_PIPE_OVF_EN.
module padder_pipe
  import padder_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  input  logic         chain,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout
`ifdef PADDER_PIPE_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int L = padder_levels(N);
  localparam int R = STAGES - 1;

  logic         advance;
  logic [N-1:0] b_eff;

  wire  [N-1:0] tp_out [0:L];
  wire  [N-1:0] tg_out [0:L];
  wire  [N-1:0] tp_in  [1:L+1];
  wire  [N-1:0] tg_in  [1:L+1];
  logic [N-1:0] h_in   [0:L+1];
  ctl_t         ctl_in [0:L+1];

  logic [N-1:0] s_d, s_q;
  logic         cout_d, cout_q;
  logic         out_valid_d, out_valid_q;
  logic         carry_d, carry_q;
  logic         c_fwd, c_use;
  logic [N:0]   carry_w;
`ifdef PADDER_PIPE_OVF_EN
  logic         ovf_d, ovf_q;
`endif

  assign advance  = out_ready || !out_valid_q;
  assign in_ready = advance;

  assign b_eff     = sub ? ~b : b;
  assign tp_out[0] = a ^ b_eff;
  assign tg_out[0] = a & b_eff;
  assign h_in[0]   = a ^ b_eff;
  assign ctl_in[0] = '{valid: in_valid, chain: chain, cin: (sub | cin)};

  for (genvar l = 1; l <= L + 1; l++) begin : g_lvl
    if (padder_is_cut(l - 1, L, R)) begin : g_reg
      pg_t  [N-1:0] pg_d, pg_q;
      logic [N-1:0] h_d, h_q;
      ctl_t         ctl_d, ctl_q;

      always_comb begin
        pg_d  = pg_q;
        h_d   = h_q;
        ctl_d = ctl_q;
        if (advance) begin
          for (int i = 0; i < N; i++) begin
            pg_d[i] = '{p: tp_out[l-1][i], g: tg_out[l-1][i]};
          end
          h_d   = h_in[l-1];
          ctl_d = ctl_in[l-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          pg_q  <= '0;
          h_q   <= '0;
          ctl_q <= '0;
        end else begin
          pg_q  <= pg_d;
          h_q   <= h_d;
          ctl_q <= ctl_d;
        end
      end

      for (genvar i = 0; i < N; i++) begin : g_unpack
        assign tp_in[l][i] = pg_q[i].p;
        assign tg_in[l][i] = pg_q[i].g;
      end
      assign h_in[l]   = h_q;
      assign ctl_in[l] = ctl_q;
    end else begin : g_pass
      assign tp_in[l]  = tp_out[l-1];
      assign tg_in[l]  = tg_out[l-1];
      assign h_in[l]   = h_in[l-1];
      assign ctl_in[l] = ctl_in[l-1];
    end

    // Sklansky level: each upper-half bit of a block combines with the block's lower half top bit.
    if (l <= L) begin : g_tree
      for (genvar i = 0; i < N; i++) begin : g_bit
        if (((i >> (l - 1)) % 2) == 1) begin : g_cell
          localparam int LO = ((i >> (l - 1)) << (l - 1)) - 1;
          padder_pg_cell u_cell (
            .Phi (tp_in[l][i]),
            .Plo (tp_in[l][LO]),
            .Ghi (tg_in[l][i]),
            .Glo (tg_in[l][LO]),
            .P   (tp_out[l][i]),
            .G   (tg_out[l][i])
          );
        end else begin : g_thru
          assign tp_out[l][i] = tp_in[l][i];
          assign tg_out[l][i] = tg_in[l][i];
        end
      end
    end
  end

  // A chained beat in the final stage takes the carry of the result leaving this cycle, if any.
  always_comb begin
    c_fwd      = out_valid_q ? cout_q : carry_q;
    c_use      = ctl_in[L+1].chain ? c_fwd : ctl_in[L+1].cin;
    carry_w    = '0;
    carry_w[0] = c_use;
    for (int i = 0; i < N; i++) begin
      carry_w[i+1] = tg_in[L+1][i] | (tp_in[L+1][i] & c_use);
    end
  end

  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    carry_d     = carry_q;
`ifdef PADDER_PIPE_OVF_EN
    ovf_d       = ovf_q;
`endif
    if (out_valid_q && out_ready) carry_d = cout_q;
    if (advance) begin
      out_valid_d = ctl_in[L+1].valid;
      if (ctl_in[L+1].valid) begin
        s_d    = h_in[L+1] ^ carry_w[N-1:0];
        cout_d = carry_w[N];
`ifdef PADDER_PIPE_OVF_EN
        ovf_d  = carry_w[N] ^ carry_w[N-1];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
`ifdef PADDER_PIPE_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
`ifdef PADDER_PIPE_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
`ifdef PADDER_PIPE_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_padder_pipe.sv
// Directed and random checks of padder_pipe at N=32, STAGES=2.
module tb_padder_pipe;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         chain;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
`ifdef PADDER_PIPE_OVF_EN
  logic         ovf;
`endif

  int           checks = 0;
  int           errors = 0;
  logic [N+1:0] exp_q[$];
  logic         model_carry;

  padder_pipe #(.N(N), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .chain     (chain),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef PADDER_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv,
                               input logic cv, input logic sv, input logic chv);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
    sub      = sv;
    chain    = chv;
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [N-1:0] es, input logic ec);
    checks++;
    assert ({out_valid, cout, s} === {ev, ec, es}) else begin
      errors++;
      $error("[TB] FAIL %s: got valid=%b cout=%b s=%h, want valid=%b cout=%b s=%h",
             tag, out_valid, cout, s, ev, ec, es);
    end
  endtask

  task automatic checkBit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %b, want %b", tag, got, exp);
    end
  endtask

  task automatic pushModel();
    logic [N-1:0] bb;
    logic         c;
    logic [N:0]   sum;
    logic         ov;
    bb  = sub ? ~b : b;
    c   = chain ? model_carry : (sub ? 1'b1 : cin);
    sum = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, c};
    ov  = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]);
    model_carry = sum[N];
    exp_q.push_back({ov, sum});
  endtask

  task automatic popCheck(input string tag);
    logic [N+1:0] e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("[TB] FAIL %s_extra: got unexpected result s=%h, want no result", tag, s);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput(tag, 1'b1, e[N-1:0], e[N]);
`ifdef PADDER_PIPE_OVF_EN
      checkBit({tag, "_ovf"}, ovf, e[N+1]);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; chain = 1'b0;
    out_ready = 1'b1; model_carry = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset", 1'b0, 32'h0, 1'b0);
    checkBit("reset_in_ready", in_ready, 1'b1);

    applyStimulus(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    checkBit("latency_not_early", out_valid, 1'b0);
    tick(); checkOutput("add_wrap", 1'b1, 32'h0, 1'b1);
    tick(); checkBit("add_wrap_leaves", out_valid, 1'b0);

    applyStimulus(32'd5, 32'd7, 1'b0, 1'b1, 1'b0);
    tick(); in_valid = 1'b0;
    tick(); checkOutput("sub_negative", 1'b1, 32'hFFFFFFFE, 1'b0);
    tick();

    applyStimulus(32'h80000000, 32'h1, 1'b0, 1'b1, 1'b0);
    tick(); in_valid = 1'b0;
    tick(); checkOutput("sub_overflow", 1'b1, 32'h7FFFFFFF, 1'b1);
`ifdef PADDER_PIPE_OVF_EN
    checkBit("sub_overflow_ovf", ovf, 1'b1);
`endif
    tick();

    applyStimulus(32'h12345678, 32'h11111111, 1'b1, 1'b0, 1'b0);
    tick(); in_valid = 1'b0;
    tick(); checkOutput("add_cin", 1'b1, 32'h2345678A, 1'b0);
`ifdef PADDER_PIPE_OVF_EN
    checkBit("add_cin_ovf", ovf, 1'b0);
`endif
    tick();

    applyStimulus(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick(); in_valid = 1'b0;
    checkOutput("chain_add_lo", 1'b1, 32'h0, 1'b1);
    tick(); checkOutput("chain_add_hi", 1'b1, 32'h1, 1'b0);
    tick(); checkBit("chain_add_done", out_valid, 1'b0);

    applyStimulus(32'h0, 32'h1, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(32'd5, 32'd2, 1'b0, 1'b1, 1'b1);
    tick(); in_valid = 1'b0;
    checkOutput("chain_sub_lo", 1'b1, 32'hFFFFFFFF, 1'b0);
    tick(); checkOutput("chain_sub_hi", 1'b1, 32'h2, 1'b1);
    tick();

    out_ready = 1'b0;
    applyStimulus(32'd10, 32'd1, 1'b0, 1'b0, 1'b0);
    tick();
    checkBit("stall_ready_filling", in_ready, 1'b1);
    applyStimulus(32'd20, 32'd2, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("stall_head", 1'b1, 32'd11, 1'b0);
    checkBit("stall_ready_full", in_ready, 1'b0);
    applyStimulus(32'd30, 32'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("stall_hold", 1'b1, 32'd11, 1'b0);
      checkBit("stall_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    checkOutput("stall_second", 1'b1, 32'd22, 1'b0);
    tick(); checkOutput("stall_third", 1'b1, 32'd33, 1'b0);
    tick(); checkBit("stall_drained", out_valid, 1'b0);

    applyStimulus(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("pre_reset_second", 1'b1, 32'h0, 1'b1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    checkOutput("mid_reset", 1'b0, 32'h0, 1'b0);
    checkBit("mid_reset_ready", in_ready, 1'b1);
    tick(); checkBit("mid_reset_no_leftover", out_valid, 1'b0);
    applyStimulus(32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
    tick(); in_valid = 1'b0;
    tick(); checkOutput("chain_after_reset", 1'b1, 32'd11, 1'b0);
    tick();

    rst = 1'b1; tick(); rst = 1'b0;
    model_carry = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      b         = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      sub       = 1'($urandom_range(0, 1));
      chain     = 1'($urandom_range(0, 1));
      cin       = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) popCheck("random");
      if (in_valid && in_ready) pushModel();
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (out_valid) popCheck("drain");
      @(posedge clk); #1;
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("[TB] FAIL random_lost: got %0d results missing, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
